// File: rtl/psr_pkg.sv
// rtl/psr_pkg.sv - shared constants and helpers for the processor status register
package psr_pkg;

   // Update classes selected by the decoder
   localparam logic [1:0] UPD_NONE  = 2'b00;
   localparam logic [1:0] UPD_ARITH = 2'b01;
   localparam logic [1:0] UPD_CMP   = 2'b10;
   localparam logic [1:0] UPD_ALL   = 2'b11;

   // Condition codes for Bcond / Jcond / Scond
   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_FS = 4'd4;
   localparam logic [3:0] COND_FC = 4'd5;
   localparam logic [3:0] COND_LT = 4'd6;
   localparam logic [3:0] COND_GE = 4'd7;
   localparam logic [3:0] COND_GT = 4'd8;
   localparam logic [3:0] COND_LE = 4'd9;
   localparam logic [3:0] COND_MI = 4'd10;
   localparam logic [3:0] COND_PL = 4'd11;
   localparam logic [3:0] COND_UC = 4'd12;
   localparam logic [3:0] COND_NV = 4'd13;

   // Bit positions of the flags in the architectural PSR word
   localparam int PSR_C = 0;
   localparam int PSR_L = 2;
   localparam int PSR_F = 5;
   localparam int PSR_Z = 6;
   localparam int PSR_N = 7;

   // Positions inside the packed 5-bit flag vector {C, L, F, Z, N}
   localparam int FLAG_W = 5;
   localparam int FLAG_C = 4;
   localparam int FLAG_L = 3;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 0;

   // Which flag bits an update class is allowed to overwrite
   function automatic logic [FLAG_W-1:0] class_mask(input logic [1:0] cls);
      case (cls)
         UPD_ARITH: class_mask = 5'b10100;
         UPD_CMP:   class_mask = 5'b01011;
         UPD_ALL:   class_mask = 5'b11111;
         default:   class_mask = 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/psr_cond_eval.sv
// rtl/psr_cond_eval.sv - condition code evaluator, shared with the branch unit
module psr_cond_eval
   import psr_pkg::*;
(
   input  logic [FLAG_W-1:0] flags,
   input  logic [3:0]        cond,
   output logic              cond_true
);

   logic c, l, f, z, n;

   assign c = flags[FLAG_C];
   assign l = flags[FLAG_L];
   assign f = flags[FLAG_F];
   assign z = flags[FLAG_Z];
   assign n = flags[FLAG_N];

   // Decode the condition code against the flags; codes 13-15 never take
   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_EQ: cond_true = z;
         COND_NE: cond_true = ~z;
         COND_CS: cond_true = c;
         COND_CC: cond_true = ~c;
         COND_FS: cond_true = f;
         COND_FC: cond_true = ~f;
         COND_LT: cond_true = l;
         COND_GE: cond_true = ~l;
         COND_GT: cond_true = ~l & ~z;
         COND_LE: cond_true = l | z;
         COND_MI: cond_true = n;
         COND_PL: cond_true = ~n;
         COND_UC: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/psr_unit.sv
// rtl/psr_unit.sv - processor status register with condition evaluation and interrupt shadow
module psr_unit
   import psr_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4:0]            flags_in,
   input  logic                  upd_valid,
   input  logic [1:0]            upd_class,
   input  logic [3:0]            cond,
   output logic                  cond_true,
   output logic [DATA_WIDTH-1:0] scond_out,
   input  logic                  psr_wr,
   input  logic [DATA_WIDTH-1:0] psr_wdata,
   output logic [DATA_WIDTH-1:0] psr_rdata,
   input  logic                  save,
   input  logic                  restore,
   output logic                  shadow_valid,
   output logic                  seq_err
);

   logic [FLAG_W-1:0] flags;
   logic [FLAG_W-1:0] flags_next;
   logic [FLAG_W-1:0] shadow;
   logic [FLAG_W-1:0] wdata_flags;
   logic [FLAG_W-1:0] upd_mask;
   logic              restore_go;
   logic              seq_err_next;
   logic              unused_wdata;

   // Only the five architectural bits of the written word matter
   assign wdata_flags  = {psr_wdata[PSR_C], psr_wdata[PSR_L], psr_wdata[PSR_F],
                          psr_wdata[PSR_Z], psr_wdata[PSR_N]};
   assign unused_wdata = ^psr_wdata;

   assign upd_mask   = class_mask(upd_class);
   assign restore_go = restore & shadow_valid;

   // A restore is illegal without a pending save; a save is illegal when the
   // shadow is already occupied or when it collides with a restore
   assign seq_err_next = (restore & ~shadow_valid) | (save & (restore | shadow_valid));

   // Single writer per cycle: restore, then LPR, then the ALU update
   always_comb begin
      flags_next = flags;
      if (restore_go) begin
         flags_next = shadow;
      end else if (psr_wr) begin
         flags_next = wdata_flags;
      end else if (upd_valid) begin
         flags_next = (flags & ~upd_mask) | (flags_in & upd_mask);
      end
   end

   // PSR, shadow and sequencing-error state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags        <= '0;
         shadow       <= '0;
         shadow_valid <= 1'b0;
         seq_err      <= 1'b0;
      end else begin
         flags   <= flags_next;
         seq_err <= seq_err_next;
         if (restore_go) begin
            shadow_valid <= 1'b0;
         end else if (save && !restore) begin
            shadow       <= flags;
            shadow_valid <= 1'b1;
         end
      end
   end

   // Expose the held flags in the architectural bit layout
   always_comb begin
      psr_rdata        = '0;
      psr_rdata[PSR_C] = flags[FLAG_C];
      psr_rdata[PSR_L] = flags[FLAG_L];
      psr_rdata[PSR_F] = flags[FLAG_F];
      psr_rdata[PSR_Z] = flags[FLAG_Z];
      psr_rdata[PSR_N] = flags[FLAG_N];
   end

   psr_cond_eval u_cond_eval (
      .flags     (flags),
      .cond      (cond),
      .cond_true (cond_true)
   );

   assign scond_out = {{(DATA_WIDTH-1){1'b0}}, cond_true};

endmodule

// File: doc/psr_unit.md
# psr_unit

Processor status register for the 16-bit datapath, directly downstream of the ALU. It captures the ALU's C, L, F, Z, N flags under an instruction-selected update class and holds them across instructions. It evaluates a 4-bit condition code against the held flags for Bcond, Jcond and Scond. It also provides a PSR read/write path and a one-level shadow copy for interrupt entry and exit.

## Interface
- DATA_WIDTH, 16, width of psr_wdata, psr_rdata and scond_out.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flags_in  in  5  ALU flags {C, L, F, Z, N}
- upd_valid  in  1  qualifies upd_class this cycle
- upd_class  in  2  update class: 00 NONE, 01 ARITH (C, F), 10 CMP (L, Z, N), 11 ALL (C, L, F, Z, N)
- cond  in  4  condition code to evaluate
- cond_true  out  1  combinational result of cond against the registered PSR
- scond_out  out  DATA_WIDTH  zero-extended cond_true (1 or 0) for Scond
- psr_wr  in  1  load PSR from psr_wdata (LPR)
- psr_wdata  in  DATA_WIDTH  C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7; other bits are ignored
- psr_rdata  out  DATA_WIDTH  current PSR in the same layout; all other bits 0
- save  in  1  copy PSR to shadow (interrupt entry)
- restore  in  1  copy shadow to PSR (interrupt exit)
- shadow_valid  out  1  shadow holds an unrestored save
- seq_err  out  1  one-cycle pulse on a sequencing error

## Operation
- **Reset.** psr=0, shadow=0, shadow_valid=0, seq_err=0. As a result, cond_true reflects all-zero flags.
- **Flag write priority, per cycle.** restore (only when shadow_valid=1) > psr_wr > upd_valid. Exactly one source writes the PSR.
- **Update classes.** Each class overwrites only its listed bits; all other PSR bits hold. upd_valid=0 or class NONE leaves the PSR unchanged.
- **Condition codes.**
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 FS: F
  - 5 FC: ~F
  - 6 LT: L
  - 7 GE: ~L
  - 8 GT: ~L&~Z
  - 9 LE: L|Z
  - 10 MI: N
  - 11 PL: ~N
  - 12 UC: 1
  - 13–15 NV: 0
- **save.**
  - shadow <= PSR value before this edge; shadow_valid <= 1.
  - If shadow_valid was already 1: overwrite the shadow and pulse seq_err (nesting overflow).
- **restore.**
  - With shadow_valid=1: PSR <= shadow; shadow_valid <= 0.
  - With shadow_valid=0: ignored, and seq_err pulses.
- **save and restore in the same cycle.** restore executes and save is dropped. seq_err pulses if restore executed; if restore was ignored (shadow_valid=0), save is still dropped and seq_err pulses once.
- **save with a simultaneous update or psr_wr.** The shadow captures the old PSR; the PSR takes the new value.

## Timing
- Every PSR, shadow and shadow_valid change takes effect at the rising clk edge. Write-to-read latency is 1 cycle.
- cond_true, scond_out and psr_rdata are combinational from registered state only. There is no bypass of flags_in: a branch in the same cycle as its compare sees the old flags. The control FSM spaces them by at least one cycle.
- seq_err is registered: it is high for exactly the one cycle following the offending edge.
- Reset assertion mid-operation clears all state immediately, independent of clk. Deassertion is synchronised externally.

## Structure
- **Shared package psr_pkg:**
  - update-class constants UPD_NONE/ARITH/CMP/ALL
  - condition-code constants COND_EQ … COND_NV
  - PSR bit-position constants PSR_C=0, PSR_L=2, PSR_F=5, PSR_Z=6, PSR_N=7
- **Sub-module psr_cond_eval:** purely combinational; takes the 5 flags and cond, produces cond_true. It is reused by the branch unit.
- **Top level:** PSR register, shadow register, priority mux, seq_err flop.

## Test plan
- Reset, then upd_valid=1, class CMP, flags_in {C,L,F,Z,N}=11111 -> psr_rdata=0x00C4; cond EQ true, CS false.
- psr_wr with psr_wdata=0xFFFF, then ARITH with flags 00000 in the next cycle -> psr_rdata=0x00C4 after the first edge is 0x00E5, becoming 0x00C4 (C, F cleared, L, Z, N held).
- Sweep all 16 cond values for PSR=0x0000 and PSR=0x00E5 -> matches the table; GT=1 only when L=0, Z=0; scond_out=0x0001 or 0x0000.
- PSR=0x0041, save and CMP update with 00000 in the same cycle -> shadow_valid=1, psr_rdata=0x0001; restore -> psr_rdata=0x0041, shadow_valid=0.
- restore with shadow_valid=0 -> PSR unchanged, seq_err high for one cycle; save twice -> second save overwrites, seq_err pulses.
- Assert rst_n low between clock edges with PSR=0x00E5, shadow_valid=1 -> outputs 0 immediately, before the next edge.
